// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous transmit FIFO between the bus-side transmit-data register
//   write path and the UART transmitter. Bytes written by the bus are
//   buffered here. The next byte reaches the transmitter on a registered
//   output, one clock after an accepted read strobe.
//
// Parameters
//   WIDTH      data word width
//   ADDR_W     log2 of depth (depth = 2**ADDR_W)
//   AFULL_LVL  fill level at or above which afull asserts (1..2**ADDR_W-1)
//
// Ports
//   clk           system clock, all state on rising edge
//   reset_n       asynchronous active-low reset
//   wr_n          active-low write strobe, one word per clock while low
//   data_in       write data, sampled when wr_n is low
//   rd_n          active-low read strobe from the transmitter
//   data_out      registered read data, holds until the next accepted read
//   fifo_empty    count == 0
//   fifo_full     count == 2**ADDR_W
//   afull         count >= AFULL_LVL
//   fifo_count    current fill level, 0..2**ADDR_W
//   overflow      sticky, set by a write attempted while full
//   clr_overflow  synchronous clear of overflow (a set in the same cycle wins)
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_n,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              rd_n,
  output logic [WIDTH-1:0]  data_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              afull,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Sized constants keep every compare and increment width-exact.
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              overflow_q, overflow_d;

  // -------------------------------------------------------------------------
  // Status decode
  // -------------------------------------------------------------------------
  // The flags come straight from the count register. They are a function of
  // one register only, so they do not glitch on pointer activity.
  logic empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  // -------------------------------------------------------------------------
  // Accept decisions, taken against pre-edge state
  // -------------------------------------------------------------------------
  // Rejection uses pre-edge full. A read in the same cycle does not make
  // room for a write. Likewise a write into an empty FIFO cannot be read
  // in that cycle, so there is no fall-through.
  logic wr_req, rd_req;
  logic wr_acc, rd_acc;

  assign wr_req = ~wr_n;
  assign rd_req = ~rd_n;
  assign wr_acc = wr_req & ~full;
  assign rd_acc = rd_req & ~empty;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q;

    // The pointers are exactly ADDR_W bits, so they wrap on their own.
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
    end

    // The count is held separately from the pointers. This lets full and
    // empty be told apart when the pointers are equal.
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A write attempt while full sets overflow even when a read is accepted
    // in the same cycle. The set takes priority over the clear.
    if (wr_req && full)     overflow_d = 1'b1;
    else if (clr_overflow)  overflow_d = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // The storage array has no reset. After a reset, count is zero, so no
  // stale entry can be read before it is written again.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign data_out   = data_out_q;
  assign fifo_empty = empty;
  assign fifo_full  = full;
  assign afull      = (count_q >= AFULL_CNT);
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_n = 1'b1;
  logic              rd_n = 1'b1;
  logic              clr_overflow = 1'b0;
  logic [WIDTH-1:0]  data_in = '0;
  logic [WIDTH-1:0]  data_out;
  logic              fifo_empty, fifo_full, afull, overflow;
  logic [ADDR_W:0]   fifo_count;

  int n_chk = 0;
  int n_err = 0;

  uart_tx_fifo #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AFULL_LVL(12)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_n         (wr_n),
    .data_in      (data_in),
    .rd_n         (rd_n),
    .data_out     (data_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .afull        (afull),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive after a falling edge and let the rising
  // edge act. Return on the next falling edge with the strobes idle.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_n = ~w; rd_n = ~r; data_in = d; clr_overflow = c;
    @(posedge clk);
    @(negedge clk);
    wr_n = 1'b1; rd_n = 1'b1; clr_overflow = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic st(input string tag, input int cnt, input logic emp, input logic ful,
                    input logic af, input logic ov);
    chk({tag, ".count"},    32'(fifo_count), 32'(cnt));
    chk({tag, ".empty"},    32'(fifo_empty), 32'(emp));
    chk({tag, ".full"},     32'(fifo_full),  32'(ful));
    chk({tag, ".afull"},    32'(afull),      32'(af));
    chk({tag, ".overflow"}, 32'(overflow),   32'(ov));
  endtask

  initial begin
    // Reset state, checked while reset is still asserted.
    #1;
    st("rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.data_out", 32'(data_out), 32'h00);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    st("idle", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // A read while empty is ignored.
    rd();
    chk("rd_empty.data_out", 32'(data_out), 32'h00);
    chk("rd_empty.count", 32'(fifo_count), 0);

    // Basic write, then read.
    wr(8'h41); wr(8'h42); wr(8'h43);
    chk("abc.count", 32'(fifo_count), 3);
    rd(); chk("abc.rd0", 32'(data_out), 32'h41);
    rd(); chk("abc.rd1", 32'(data_out), 32'h42);
    rd(); chk("abc.rd2", 32'(data_out), 32'h43);
    chk("abc.empty", 32'(fifo_empty), 1);

    // Fill to full, watching afull and full, then overflow.
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      chk("fill.count", 32'(fifo_count), 32'(i + 1));
      chk("fill.afull", 32'(afull), 32'((i + 1) >= 12));
      chk("fill.full",  32'(fifo_full), 32'(i == 15));
    end
    wr(8'hFF);
    st("ovf", 16, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      rd();
      chk("drain.data", 32'(data_out), 32'(i));
    end
    st("drain.end", 0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.overflow", 32'(overflow), 0);

    // Pointer wrap: the pointers start mid-array here, so 2x10 crosses 15->0.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) wr(8'(8'h80 + 8'(r * 16) + 8'(i)));
      chk("wrap.count", 32'(fifo_count), 10);
      for (int i = 0; i < 10; i++) begin
        rd();
        chk("wrap.data", 32'(data_out), 32'(8'h80 + r * 16 + i));
      end
      chk("wrap.zero", 32'(fifo_count), 0);
    end

    // Write and read in the same cycle while empty: no fall-through.
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("sim_empty.count", 32'(fifo_count), 1);
    chk("sim_empty.data_out", 32'(data_out), 32'h99);
    rd();
    chk("sim_empty.rd", 32'(data_out), 32'h55);

    // Write and read in the same cycle with count 5.
    for (int i = 1; i <= 5; i++) wr(8'(i));
    cyc(1'b1, 8'h06, 1'b1, 1'b0);
    chk("sim_mid.count", 32'(fifo_count), 5);
    chk("sim_mid.data_out", 32'(data_out), 32'h01);
    for (int i = 2; i <= 6; i++) begin
      rd();
      chk("sim_mid.drain", 32'(data_out), 32'(i));
    end

    // Write and read in the same cycle while full: read wins, write is dropped.
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    st("sim_full", 15, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sim_full.data_out", 32'(data_out), 32'h20);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_alone", 32'(overflow), 0);
    wr(8'h30);
    chk("refill.full", 32'(fifo_full), 1);
    cyc(1'b1, 8'hFF, 1'b0, 1'b1);
    chk("set_vs_clr", 32'(overflow), 1);
    chk("set_vs_clr.count", 32'(fifo_count), 16);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_again", 32'(overflow), 0);
    for (int i = 1; i <= 16; i++) begin
      rd();
      chk("full_drain", 32'(data_out), 32'(8'h20 + i));
    end

    // Asynchronous reset between edges with count 7.
    for (int i = 0; i < 7; i++) wr(8'(8'h60 + i));
    chk("pre_rst.count", 32'(fifo_count), 7);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    st("async_rst", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("async_rst.data_out", 32'(data_out), 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd();
    chk("post_rst.rd.data", 32'(data_out), 32'h00);
    chk("post_rst.rd.count", 32'(fifo_count), 0);
    wr(8'h77);
    rd();
    chk("post_rst.wr_rd", 32'(data_out), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Synchronous transmit FIFO between the CPU/APB transmit-data register write path and the UART async transmitter.
- Buffers bytes written by the bus interface.
- Presents the next byte to the transmitter on a registered output.
- Reports empty/full/level status to both the transmitter and the status register.
- Single clock domain (system clock); consumes the transmitter's active-low read strobe.

Parameters:
- WIDTH, 8, data word width in bits
- ADDR_W, 4, log2 of depth; depth = 2**ADDR_W = 16 entries
- AFULL_LVL, 12, fill level at or above which afull asserts (range 1..2**ADDR_W-1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- wr_n  in  1  active-low write strobe, one word per clk while low
- data_in  in  WIDTH  write data, sampled when wr_n low
- rd_n  in  1  active-low read strobe from transmitter, one word per clk while low
- data_out  out  WIDTH  registered read data; updates on clk after an accepted read, else holds
- fifo_empty  out  1  high when count == 0
- fifo_full  out  1  high when count == 2**ADDR_W
- afull  out  1  high when count >= AFULL_LVL
- fifo_count  out  ADDR_W+1  current fill level, 0..2**ADDR_W
- overflow  out  1  sticky: write attempted while full
- clr_overflow  in  1  synchronous clear of overflow (status-register read side effect)

Behaviour:
- Reset (async assert, sync-to-clk release):
  - wr_ptr = rd_ptr = 0, count = 0, data_out = 0, overflow = 0
  - fifo_empty = 1, fifo_full = 0, afull = 0
  - Storage contents undefined and need no reset.
- Storage: 2**ADDR_W x WIDTH array. Pointers are ADDR_W bits and wrap naturally from 2**ADDR_W-1 to 0. count is a separate ADDR_W+1-bit register.
- Accept rules, evaluated on each rising edge against pre-edge state:
  - write accepted = !wr_n && !full
  - read accepted = !rd_n && !empty
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr++.
- Accepted read: data_out <= mem[rd_ptr]; rd_ptr++. Read latency is 1 clk from the strobe edge to valid data_out. data_out holds its value until the next accepted read. The transmitter latches data_out at least 2 clks after its strobe; this is sufficient.
- count update:
  - +1 on write only
  - -1 on read only
  - unchanged on both or neither
- Flags: fifo_empty, fifo_full and afull decode combinationally from the count register, so they are glitch-free and valid the cycle after the update.
- Simultaneous write + read:
  - Both non-boundary: both complete, count unchanged.
  - Empty: write accepted, read ignored. No fall-through; data_out is unchanged and count becomes 1.
  - Full: read accepted, write rejected and overflow set; count becomes 2**ADDR_W-1. Rejection uses pre-edge full.
- Write while full (wr_n low): data dropped, pointers unchanged, overflow <= 1.
- Read while empty: ignored. data_out, pointers and count unchanged. No underflow flag; the transmitter reads only when !fifo_empty.
- overflow precedence: set has priority over clr_overflow in the same cycle.
- Held strobes: a strobe held low for N cycles performs up to N transfers, each subject to the accept rules. No edge detection.
- Reset mid-transfer: all state returns to reset values immediately. Any buffered data is discarded.

Test Plan:
- Reset, then idle: fifo_empty=1, fifo_full=0, fifo_count=0, data_out=0x00, overflow=0; rd_n pulse -> data_out stays 0x00, count stays 0.
- Write 0x41,0x42,0x43 (wr_n low 1 clk each), then three 1-clk rd_n pulses -> data_out = 0x41, 0x42, 0x43, each 1 clk after its pulse; fifo_empty=1 after the third read.
- Write 16 words 0x00..0x0F -> afull rises when count reaches 12, fifo_full=1 at 16; 17th write 0xFF -> overflow=1, count=16; read all 16 -> data 0x00..0x0F, 0xFF never appears.
- Pointer wrap: write 10, read 10, write 10, read 10 with values 0x80..0x89 then 0x90..0x99 -> output order exact, count returns to 0 each round.
- Simultaneous strobes:
  - empty + wr 0x55 + rd -> count=1, data_out unchanged; next read -> 0x55
  - full + wr + rd -> count=15, overflow=1
  - count=5 + wr + rd -> count=5
  - clr_overflow together with an overflowing write -> overflow stays 1; clr alone -> 0
- Assert reset_n low mid-stream with count=7 (asynchronously, between edges) -> all outputs return to reset values immediately; after release, reads with fifo_empty=1 have no effect.
